// File: rtl/sysbus_arb_pkg.sv
// Shared types and constants for the system bus arbiter.
// Response-side signalling (including the 12'h800 invalidation tag) bypasses the arbiter entirely.
package sysbus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_BUSY  = 2'd2
    } arb_state_t;

    localparam int REQ_ICACHE = 0;
    localparam int REQ_DCACHE = 1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first requesting index
// strictly after `last`, wrapping around.
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    // Distance k = 1 is searched first, so `last` itself has lowest priority.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!valid && req[i] &&
                    ((int'(last) + k == i) || (int'(last) + k == i + NREQ))) begin
                    valid = 1'b1;
                    idx   = IDXW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// Round-robin owner arbitration for the shared system bus between icache and dcache,
// with a grant timeout and a combinational request-side mux driven by the owner register.
module sysbus_arbiter
    import sysbus_arb_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int GRANT_TIMEOUT  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NREQ-1:0]                   m_busreq,
    input  logic [NREQ-1:0]                   m_busidle,
    output logic [NREQ-1:0]                   m_busgrant,
    input  logic [NREQ-1:0]                   m_reqcyc,
    input  logic [NREQ-1:0]                   m_respack,
    input  logic [NREQ*BUS_DATA_WIDTH-1:0]    m_req,
    input  logic [NREQ*BUS_TAG_WIDTH-1:0]     m_reqtag,
    output logic                              bus_reqcyc,
    output logic                              bus_respack,
    output logic [BUS_DATA_WIDTH-1:0]         bus_req,
    output logic [BUS_TAG_WIDTH-1:0]          bus_reqtag,
    output logic [$clog2(NREQ)-1:0]           bus_owner,
    output logic                              bus_busy
);

    localparam int IDXW = $clog2(NREQ);
    localparam int CNTW = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(GRANT_TIMEOUT - 1);

    arb_state_t      state, state_next;
    logic [IDXW-1:0] owner, owner_next;
    logic [IDXW-1:0] last_owner, last_next;
    logic [CNTW-1:0] wait_cnt, cnt_next;

    logic            pick_valid;
    logic [IDXW-1:0] pick_idx;
    logic            owner_idle;
    logic            owner_reqcyc;

    rr_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_picker (
        .req   (m_busreq),
        .last  (last_owner),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owner_idle   = m_busidle[owner];
    assign owner_reqcyc = m_reqcyc[owner];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            last_owner <= IDXW'(NREQ - 1);
            wait_cnt   <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_owner <= last_next;
            wait_cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        last_next  = last_owner;
        cnt_next   = wait_cnt;
        case (state)
            ARB_IDLE: begin
                cnt_next = '0;
                if (pick_valid) begin
                    owner_next = pick_idx;
                    state_next = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!owner_idle || owner_reqcyc) begin
                    state_next = ARB_BUSY;
                    cnt_next   = '0;
                end else if (wait_cnt == CNT_LAST) begin
                    // Requester never started: revoke so the other side is not starved.
                    state_next = ARB_IDLE;
                    last_next  = owner;
                    cnt_next   = '0;
                end else begin
                    cnt_next = wait_cnt + CNTW'(1);
                end
            end
            ARB_BUSY: begin
                cnt_next = '0;
                if (owner_idle && !owner_reqcyc) begin
                    state_next = ARB_IDLE;
                    last_next  = owner;
                end
            end
            default: begin
                state_next = ARB_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Grant is visible only in ARB_GRANT so it is already low while the owner works.
    always_comb begin
        m_busgrant  = '0;
        bus_reqcyc  = 1'b0;
        bus_respack = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IDXW'(i)) begin
                if (state == ARB_GRANT) begin
                    m_busgrant[i] = 1'b1;
                end
                if (state != ARB_IDLE) begin
                    bus_reqcyc  = m_reqcyc[i];
                    bus_respack = m_respack[i];
                    bus_req     = m_req[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                    bus_reqtag  = m_reqtag[i*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
                end
            end
        end
    end

    assign bus_owner = owner;
    assign bus_busy  = (state != ARB_IDLE);

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: reset, single grant, round-robin alternation,
// grant timeout, long writeback, reset mid-transaction and non-owner isolation.
module tb_sysbus_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 64;
    localparam int TW   = 13;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   m_busreq;
    logic [NREQ-1:0]   m_busidle;
    logic [NREQ-1:0]   m_busgrant;
    logic [NREQ-1:0]   m_reqcyc;
    logic [NREQ-1:0]   m_respack;
    logic [NREQ*DW-1:0] m_req;
    logic [NREQ*TW-1:0] m_reqtag;
    logic              bus_reqcyc;
    logic              bus_respack;
    logic [DW-1:0]     bus_req;
    logic [TW-1:0]     bus_reqtag;
    logic [0:0]        bus_owner;
    logic              bus_busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sysbus_arbiter #(
        .NREQ           (NREQ),
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .GRANT_TIMEOUT  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_busreq    (m_busreq),
        .m_busidle   (m_busidle),
        .m_busgrant  (m_busgrant),
        .m_reqcyc    (m_reqcyc),
        .m_respack   (m_respack),
        .m_req       (m_req),
        .m_reqtag    (m_reqtag),
        .bus_reqcyc  (bus_reqcyc),
        .bus_respack (bus_respack),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_owner   (bus_owner),
        .bus_busy    (bus_busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled and inputs driven 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_busreq  = '0;
        m_busidle = '1;
        m_reqcyc  = '0;
        m_respack = '0;
        m_req     = '0;
        m_reqtag  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (m_busgrant !== 2'b00) $display("FAIL reset_grant got=%b exp=%b", m_busgrant, 2'b00);
        else pass_cnt++;
        total_cnt++;
        if (bus_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus_busy);
        else pass_cnt++;
        total_cnt++;
        if (bus_owner !== 1'b0) $display("FAIL reset_owner got=%0d exp=0", bus_owner);
        else pass_cnt++;
        total_cnt++;
        if (bus_req !== 64'h0 || bus_reqcyc !== 1'b0 || bus_reqtag !== 13'h0 || bus_respack !== 1'b0)
            $display("FAIL reset_bus got req=%h cyc=%b tag=%h ack=%b exp all 0",
                     bus_req, bus_reqcyc, bus_reqtag, bus_respack);
        else pass_cnt++;
    endtask

    task automatic test_single_dcache();
        do_reset();
        m_busreq = 2'b10;
        step();
        total_cnt++;
        if (m_busgrant !== 2'b10) $display("FAIL single_grant got=%b exp=10", m_busgrant);
        else pass_cnt++;
        total_cnt++;
        if (bus_owner !== 1'b1 || bus_busy !== 1'b1)
            $display("FAIL single_owner got owner=%0d busy=%b exp owner=1 busy=1", bus_owner, bus_busy);
        else pass_cnt++;
        m_busidle[1]    = 1'b0;
        m_reqcyc[1]     = 1'b1;
        m_req[DW +: DW] = 64'h8000_0040;
        m_reqtag[TW +: TW] = 13'h0005;
        #1;
        total_cnt++;
        if (bus_req !== 64'h8000_0040 || bus_reqcyc !== 1'b1 || bus_reqtag !== 13'h0005)
            $display("FAIL single_mux got req=%h cyc=%b tag=%h exp req=8000000040 cyc=1 tag=0005",
                     bus_req, bus_reqcyc, bus_reqtag);
        else pass_cnt++;
        m_busreq = 2'b00;
        step();
        total_cnt++;
        if (m_busgrant !== 2'b00 || bus_busy !== 1'b1 || bus_req !== 64'h8000_0040)
            $display("FAIL single_busy got grant=%b busy=%b req=%h exp grant=00 busy=1 req=8000000040",
                     m_busgrant, bus_busy, bus_req);
        else pass_cnt++;
        m_reqcyc[1]  = 1'b0;
        m_busidle[1] = 1'b1;
        step();
        total_cnt++;
        if (bus_busy !== 1'b0 || bus_req !== 64'h0 || bus_reqcyc !== 1'b0)
            $display("FAIL single_release got busy=%b req=%h cyc=%b exp busy=0 req=0 cyc=0",
                     bus_busy, bus_req, bus_reqcyc);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_grant;
        do_reset();
        m_busreq = 2'b11;
        step();
        for (int g = 0; g < 6; g++) begin
            exp_grant = (g % 2 == 0) ? 2'b01 : 2'b10;
            total_cnt++;
            if (m_busgrant !== exp_grant)
                $display("FAIL rr_grant%0d got=%b exp=%b", g, m_busgrant, exp_grant);
            else pass_cnt++;
            m_busidle = ~exp_grant;
            m_reqcyc  = exp_grant;
            step();
            m_busidle = 2'b11;
            m_reqcyc  = 2'b00;
            step();
            total_cnt++;
            if (m_busgrant !== 2'b00 || bus_busy !== 1'b0)
                $display("FAIL rr_dead%0d got grant=%b busy=%b exp grant=00 busy=0", g, m_busgrant, bus_busy);
            else pass_cnt++;
            step();
        end
        m_busreq = 2'b00;
    endtask

    task automatic test_timeout();
        do_reset();
        m_busreq = 2'b01;
        for (int c = 0; c < 8; c++) begin
            step();
            if (c == 1) m_busreq = 2'b11;
            total_cnt++;
            if (m_busgrant !== 2'b01)
                $display("FAIL timeout_hold%0d got=%b exp=01", c, m_busgrant);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if (m_busgrant !== 2'b00 || bus_busy !== 1'b0)
            $display("FAIL timeout_revoke got grant=%b busy=%b exp grant=00 busy=0", m_busgrant, bus_busy);
        else pass_cnt++;
        step();
        total_cnt++;
        if (m_busgrant !== 2'b10 || bus_owner !== 1'b1)
            $display("FAIL timeout_next got grant=%b owner=%0d exp grant=10 owner=1", m_busgrant, bus_owner);
        else pass_cnt++;
        m_busreq = 2'b00;
    endtask

    task automatic test_writeback();
        do_reset();
        m_busreq = 2'b10;
        step();
        total_cnt++;
        if (m_busgrant !== 2'b10) $display("FAIL wb_grant got=%b exp=10", m_busgrant);
        else pass_cnt++;
        m_busidle[1] = 1'b0;
        m_busreq     = 2'b00;
        for (int c = 0; c < 9; c++) begin
            step();
            if (c == 2) m_busreq = 2'b01;
            total_cnt++;
            if (m_busgrant !== 2'b00 || bus_busy !== 1'b1)
                $display("FAIL wb_hold%0d got grant=%b busy=%b exp grant=00 busy=1", c, m_busgrant, bus_busy);
            else pass_cnt++;
        end
        m_busidle[1] = 1'b1;
        step();
        total_cnt++;
        if (m_busgrant !== 2'b00 || bus_busy !== 1'b0)
            $display("FAIL wb_dead got grant=%b busy=%b exp grant=00 busy=0", m_busgrant, bus_busy);
        else pass_cnt++;
        step();
        total_cnt++;
        if (m_busgrant !== 2'b01 || bus_owner !== 1'b0)
            $display("FAIL wb_next got grant=%b owner=%0d exp grant=01 owner=0", m_busgrant, bus_owner);
        else pass_cnt++;
        m_busreq = 2'b00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_busreq = 2'b10;
        step();
        m_busidle[1]    = 1'b0;
        m_reqcyc[1]     = 1'b1;
        m_req[DW +: DW] = 64'h0000_0000_CAFE_F00D;
        m_busreq        = 2'b11;
        step();
        total_cnt++;
        if (bus_busy !== 1'b1 || bus_req !== 64'h0000_0000_CAFE_F00D)
            $display("FAIL midrst_pre got busy=%b req=%h exp busy=1 req=00000000cafef00d", bus_busy, bus_req);
        else pass_cnt++;
        reset = 1'b0;
        step();
        total_cnt++;
        if (m_busgrant !== 2'b00 || bus_reqcyc !== 1'b0 || bus_req !== 64'h0 || bus_busy !== 1'b0)
            $display("FAIL midrst_abort got grant=%b cyc=%b req=%h busy=%b exp all 0",
                     m_busgrant, bus_reqcyc, bus_req, bus_busy);
        else pass_cnt++;
        reset = 1'b1;
        clear_inputs();
    endtask

    task automatic test_nonowner();
        do_reset();
        m_busreq = 2'b01;
        step();
        m_busidle          = 2'b00;
        m_reqcyc           = 2'b11;
        m_respack          = 2'b10;
        m_req[0 +: DW]     = 64'h1234;
        m_req[DW +: DW]    = 64'hDEAD;
        m_reqtag[0 +: TW]  = 13'h0042;
        m_reqtag[TW +: TW] = 13'h1FFF;
        #1;
        total_cnt++;
        if (bus_req !== 64'h1234 || bus_reqtag !== 13'h0042 || bus_respack !== 1'b0)
            $display("FAIL nonowner_grant got req=%h tag=%h ack=%b exp req=1234 tag=0042 ack=0",
                     bus_req, bus_reqtag, bus_respack);
        else pass_cnt++;
        m_busreq = 2'b00;
        step();
        m_respack = 2'b01;
        #1;
        total_cnt++;
        if (bus_req !== 64'h1234 || bus_respack !== 1'b1 || bus_reqcyc !== 1'b1)
            $display("FAIL nonowner_busy got req=%h ack=%b cyc=%b exp req=1234 ack=1 cyc=1",
                     bus_req, bus_respack, bus_reqcyc);
        else pass_cnt++;
        m_reqcyc[0]  = 1'b0;
        m_busidle[0] = 1'b1;
        step();
        total_cnt++;
        if (bus_busy !== 1'b0 || bus_req !== 64'h0)
            $display("FAIL nonowner_release got busy=%b req=%h exp busy=0 req=0", bus_busy, bus_req);
        else pass_cnt++;
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_single_dcache();
        test_round_robin();
        test_timeout();
        test_writeback();
        test_reset_mid();
        test_nonowner();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
